// File: rtl/fmul_arbiter.sv
// Shares one non-stalling pipelined fmul unit among NREQ requesters using round-robin issue.
// Each result goes back to the slot of the requester that issued it, and the slot holds it until accepted.
module fmul_arbiter #(
  parameter int NREQ     = 4,
  parameter int FMUL_LAT = 1,
  parameter int IDW      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_s,
  input  logic [32*NREQ-1:0]   req_t,
  output logic [NREQ-1:0]      res_valid,
  input  logic [NREQ-1:0]      res_ready,
  output logic [32*NREQ-1:0]   res_d,
  output logic [NREQ-1:0]      res_ovf,
  output logic [NREQ-1:0]      res_unf,
  output logic [31:0]          fmul_s,
  output logic [31:0]          fmul_t,
  input  logic [31:0]          fmul_d,
  input  logic                 fmul_ovf,
  input  logic                 fmul_unf
);
  localparam int DATA_W = 32;
  localparam int LAST   = FMUL_LAT - 1;

  logic [NREQ-1:0]        r_busy;
  logic [IDW-1:0]         r_rr_ptr;
  logic [NREQ-1:0]        w_elig;
  int                     w_dist [NREQ];
  int                     w_best_dist;
  int                     w_win_idx;
  logic                   w_grant;
  logic [IDW-1:0]         w_winner;
  logic [IDW-1:0]         w_rr_nxt;
  logic [NREQ-1:0]        w_req_ready;
  logic [DATA_W-1:0]      w_fmul_s;
  logic [DATA_W-1:0]      w_fmul_t;

  logic [FMUL_LAT-1:0]    r_vld_p;
  logic [IDW-1:0]         r_id_p [FMUL_LAT];
  logic [NREQ-1:0]        w_capture;

  logic [NREQ-1:0]        r_res_valid;
  logic [NREQ-1:0]        r_res_ovf;
  logic [NREQ-1:0]        r_res_unf;
  logic [DATA_W*NREQ-1:0] r_res_d;
  logic [NREQ-1:0]        w_req_hs;
  logic [NREQ-1:0]        w_res_hs;

  // Issue stage: a requester with an outstanding operation is not eligible.
  assign w_elig = req_valid & ~r_busy;

  // Winner = eligible index with the smallest upward distance from the round-robin pointer.
  always_comb begin
    w_best_dist = NREQ;
    w_win_idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist[i] = i - int'(r_rr_ptr);
      if (w_dist[i] < 0) w_dist[i] = w_dist[i] + NREQ;
      if (w_elig[i] && (w_dist[i] < w_best_dist)) begin
        w_best_dist = w_dist[i];
        w_win_idx   = i;
      end
    end
    w_grant  = !rst && (w_best_dist < NREQ);
    w_winner = IDW'(w_win_idx);
    w_rr_nxt = (w_win_idx == NREQ - 1) ? '0 : IDW'(w_win_idx + 1);
  end

  always_comb begin
    w_req_ready = '0;
    w_fmul_s    = '0;
    w_fmul_t    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant && (w_win_idx == i)) begin
        w_req_ready[i] = 1'b1;
        w_fmul_s       = req_s[DATA_W*i +: DATA_W];
        w_fmul_t       = req_t[DATA_W*i +: DATA_W];
      end
    end
  end

  assign req_ready = w_req_ready;
  assign fmul_s    = w_fmul_s;
  assign fmul_t    = w_fmul_t;
  assign w_req_hs  = req_valid & w_req_ready;
  assign w_res_hs  = r_res_valid & res_ready;

  // In-flight stages: shadow the fmul pipeline with {valid, id}; never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p <= '0;
      for (int s = 0; s < FMUL_LAT; s++) r_id_p[s] <= '0;
    end else begin
      r_vld_p[0] <= w_grant;
      r_id_p[0]  <= w_winner;
      for (int s = 1; s < FMUL_LAT; s++) begin
        r_vld_p[s] <= r_vld_p[s-1];
        r_id_p[s]  <= r_id_p[s-1];
      end
    end
  end

  always_comb begin
    w_capture = '0;
    for (int i = 0; i < NREQ; i++)
      w_capture[i] = r_vld_p[LAST] && (r_id_p[LAST] == IDW'(i));
  end

  // Capture stage: the product lands in its owner's slot; the slot data outlives consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      r_rr_ptr    <= '0;
      r_res_valid <= '0;
      r_res_ovf   <= '0;
      r_res_unf   <= '0;
      r_res_d     <= '0;
    end else begin
      r_busy      <= (r_busy | w_req_hs) & ~w_res_hs;
      r_res_valid <= (r_res_valid & ~w_res_hs) | w_capture;
      if (w_grant) r_rr_ptr <= w_rr_nxt;
      for (int i = 0; i < NREQ; i++) begin
        if (w_capture[i]) begin
          r_res_d[DATA_W*i +: DATA_W] <= fmul_d;
          r_res_ovf[i]                <= fmul_ovf;
          r_res_unf[i]                <= fmul_unf;
        end
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_d     = r_res_d;
  assign res_ovf   = r_res_ovf;
  assign res_unf   = r_res_unf;

endmodule

// File: doc/fmul_arbiter.md
Name: fmul_arbiter

Overview:
- Shares one 2-stage pipelined fmul unit among NREQ requesters, e.g. the FPU issue port, the fdiv/fsqrt Newton iteration sequencer and the vector/loop unit.
- Round-robin grant of at most one multiply per cycle; the fmul unit itself cannot stall.
- Tracks the requester ID of every in-flight operation and steers each result, with its overflow/underflow flags, into that requester's result slot.
- The result slot is held until the requester accepts it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FMUL_LAT, 1, clock edges between driving fmul_s/fmul_t and the matching fmul_d/fmul_ovf/fmul_unf being valid (the 2-stage fmul gives 1).
- IDW, 3, width of the internal requester ID (must be at least clog2(NREQ)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester grant; a handshake occurs when req_valid[i] and req_ready[i] are both high.
- req_s  in  32*NREQ  operand s, requester i at bits [32i+31:32i].
- req_t  in  32*NREQ  operand t, same packing.
- res_valid  out  NREQ  result slot i is full.
- res_ready  in  NREQ  requester i consumes its result.
- res_d  out  32*NREQ  product, same packing.
- res_ovf  out  NREQ  overflow flag of the product.
- res_unf  out  NREQ  underflow flag of the product.
- fmul_s  out  32  operand s to the fmul unit.
- fmul_t  out  32  operand t to the fmul unit.
- fmul_d  in  32  product from the fmul unit.
- fmul_ovf  in  1  overflow flag from the fmul unit.
- fmul_unf  in  1  underflow flag from the fmul unit.

Behaviour:
- Reset:
  - Clears busy[], the in-flight pipe, the result slots and their flags.
  - Sets rr_ptr to 0.
  - All outputs are 0 in the cycle after rst is sampled high.
  - Any result still in the fmul unit is discarded because its in-flight entry was cleared.
- Busy flag per requester:
  - busy[i] sets on a request handshake.
  - busy[i] clears on the res_valid[i] && res_ready[i] handshake.
  - Each requester therefore has at most one operation outstanding, so a result always has a free slot and the fmul unit is never back-pressured.
- Eligibility:
  - elig[i] = req_valid[i] && !busy[i], where busy is the registered value.
  - A requester whose result is consumed in cycle c becomes eligible in cycle c+1, not in cycle c.
- Arbitration:
  - Combinational round-robin: the winner is the first eligible index at or after rr_ptr, searching upward with wrap-around.
  - req_ready is one-hot (the winner) or all-zero. It depends on req_valid; this is allowed.
  - On a grant, rr_ptr becomes (winner+1) mod NREQ. With no grant, rr_ptr holds.
- Operand drive:
  - fmul_s and fmul_t are combinational muxes of the winner's operands in the grant cycle.
  - With no grant they are driven to 32'h0.
- In-flight pipe:
  - FMUL_LAT stages of {valid, id}, shifting every cycle, never stalling.
  - Stage 0 loads {grant, winner}.
- Capture:
  - When the last stage is valid, fmul_d, fmul_ovf and fmul_unf are registered into slot[id], and res_valid[id] goes to 1.
- Latency:
  - A grant in cycle c gives res_valid high in cycle c+FMUL_LAT+1, i.e. c+2 by default.
  - res_valid stays high, and res_d/res_ovf/res_unf stay stable, until res_ready.
  - Slot contents are retained after consumption; only res_valid drops.
- Throughput:
  - One grant per cycle in aggregate.
  - Per requester, at best one operation every FMUL_LAT+2 cycles, i.e. 3 by default.
- Simultaneous events:
  - A grant, a capture into a different slot and a consumption of another slot in the same cycle are all independent.
  - A capture into slot i and a consumption of slot i cannot coincide, because res_valid[i] is low until the capture.
- Reset mid-operation:
  - Takes precedence over every handshake in that cycle.
  - Stale fmul_d is ignored because the pipe valids are cleared.
- Operand passthrough: no value checking; NaN, Inf and zero handling belongs to the fmul unit.

Test Plan:
- Single op: requester 0 sends s=32'h40000000, t=32'h40400000 in cycle 0.
  - req_ready[0]=1 in cycle 0.
  - res_valid[0]=1 in cycle 2 with res_d=32'h40C00000, res_ovf=0, res_unf=0.
- Full contention: all 4 requesters are valid from cycle 0 with rr_ptr=0.
  - Grants go to 0, 1, 2, 3 in cycles 0–3.
  - res_valid goes high for 0, 1, 2, 3 in cycles 2–5, each result carrying its own operands' product.
- Backpressure: requester 1 holds res_ready=0 for 10 cycles while keeping req_valid=1.
  - req_ready[1] stays 0 and res_d[1] stays stable.
  - Other requesters keep being granted.
  - Requester 1 is re-granted in the cycle after it consumes its result.
- Flags: s=t=32'h7F000000 → res_d=32'h7F800000, res_ovf=1. s=t=32'h00800000 → res_d=32'h00000000, res_unf=1.
- Reset mid-flight: assert rst one cycle after a grant.
  - No res_valid is ever produced for that operation.
  - Afterwards req_ready, res_valid and busy are 0, and rr_ptr=0 (requester 0 wins the next 4-way contention).
- Fairness: requesters 0 and 2 are continuously valid and always consume immediately.
  - Grants alternate 0, 2, 0, 2, … subject to busy.
  - Neither requester waits more than NREQ cycles for a grant once eligible.
